// File: rtl/pwm_pkg.sv
// Shared widths, timeout constant and capture FSM states for the PWM capture block.
package pwm_pkg;

    localparam int unsigned DUTY_W   = 11;
    localparam int unsigned PERIOD_W = 12;

    localparam logic [PERIOD_W-1:0] CAP_TIMEOUT = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } cap_state_t;

    // High sample count minus one, saturated into the duty word.
    function automatic logic [DUTY_W-1:0] duty_from_high(input logic [PERIOD_W-1:0] high_cnt);
        logic [PERIOD_W-1:0] m1;
        m1 = high_cnt - 1'b1;
        if (m1 > PERIOD_W'({DUTY_W{1'b1}})) begin
            return {DUTY_W{1'b1}};
        end
        return m1[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_in_cond.sv
// Input conditioning: two-flop synchronizer, optional glitch filter, history flop, edge detect.
// The glitch filter is compiled in with `define PWM_CAP_GLITCH_FILTER_EN.
module pwm_in_cond
    import pwm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1_q, sync2_q, hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            hist_q  <= level;
        end
    end

`ifdef PWM_CAP_GLITCH_FILTER_EN
    logic       filt_q;
    logic [1:0] filt_cnt_q;

    // Third consecutive differing sample flips the level in that same cycle.
    always_comb begin
        level = filt_q;
        if (sync2_q != filt_q && filt_cnt_q == 2'd2) begin
            level = sync2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q     <= 1'b0;
            filt_cnt_q <= 2'd0;
        end else begin
            filt_q <= level;
            if (sync2_q == filt_q || filt_cnt_q == 2'd2) begin
                filt_cnt_q <= 2'd0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 2'd1;
            end
        end
    end
`else
    assign level = sync2_q;
`endif

    assign rise = level & ~hist_q;
    assign fall = ~level & hist_q;

endmodule

// File: rtl/pwm_capture11.sv
// Recovers the 11-bit duty word and period of an asynchronous PWM input.
// Optional input glitch filter: `define PWM_CAP_GLITCH_FILTER_EN.
module pwm_capture11
    import pwm_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pwm_in,
    output logic [DUTY_W-1:0]   duty,
    output logic [PERIOD_W-1:0] period,
    output logic                valid,
    output logic                stuck_hi,
    output logic                stuck_lo
);

    logic level, rise, fall;

    pwm_in_cond u_cond (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    cap_state_t          state_q, state_d;
    logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
    logic [PERIOD_W-1:0] high_cnt_q, high_cnt_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                valid_q, valid_d;
    logic                stuck_hi_q, stuck_hi_d;
    logic                stuck_lo_q, stuck_lo_d;
    logic                timeout;

    // Fires only on the step into saturation, so a held counter never repeats it.
    assign timeout = (period_cnt_q == CAP_TIMEOUT - 1'b1) && !rise && !fall;

    always_comb begin
        state_d      = state_q;
        high_cnt_d   = fall ? period_cnt_q : high_cnt_q;
        duty_d       = duty_q;
        period_d     = period_q;
        valid_d      = 1'b0;
        stuck_hi_d   = stuck_hi_q;
        stuck_lo_d   = stuck_lo_q;

        if (rise) begin
            period_cnt_d = PERIOD_W'(1);
        end else if (period_cnt_q == CAP_TIMEOUT) begin
            period_cnt_d = period_cnt_q;
        end else begin
            period_cnt_d = period_cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: if (rise) state_d = HIGH;
            HIGH: if (fall) state_d = LOW;
            LOW: begin
                if (rise) begin
                    period_d   = period_cnt_q;
                    duty_d     = duty_from_high(high_cnt_q);
                    valid_d    = 1'b1;
                    stuck_hi_d = 1'b0;
                    stuck_lo_d = 1'b0;
                    state_d    = HIGH;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            if (level) begin
                stuck_hi_d = 1'b1;
                duty_d     = {DUTY_W{1'b1}};
            end else begin
                stuck_lo_d = 1'b1;
                duty_d     = '0;
            end
            period_d = '0;
            valid_d  = 1'b1;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            duty_q       <= '0;
            period_q     <= '0;
            valid_q      <= 1'b0;
            stuck_hi_q   <= 1'b0;
            stuck_lo_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            duty_q       <= duty_d;
            period_q     <= period_d;
            valid_q      <= valid_d;
            stuck_hi_q   <= stuck_hi_d;
            stuck_lo_q   <= stuck_lo_d;
        end
    end

    assign duty     = duty_q;
    assign period   = period_q;
    assign valid    = valid_q;
    assign stuck_hi = stuck_hi_q;
    assign stuck_lo = stuck_lo_q;

endmodule

// File: tb/tb_pwm_capture11.sv
// Directed bench for pwm_capture11 driven by a behavioural 11-bit PWM generator.
module tb_pwm_capture11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pwm_in = 1'b0;
    logic [10:0] duty;
    logic [11:0] period;
    logic        valid;
    logic        stuck_hi;
    logic        stuck_lo;

    pwm_capture11 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pwm_in   (pwm_in),
        .duty     (duty),
        .period   (period),
        .valid    (valid),
        .stuck_hi (stuck_hi),
        .stuck_lo (stuck_lo)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int gen_cnt = 0;

    // Latest published measurement and pulse count.
    int          v_cnt = 0;
    logic [10:0] v_duty = '0;
    logic [11:0] v_period = '0;
    logic        v_hi = 1'b0;
    logic        v_lo = 1'b0;

    always @(negedge clk) begin
        if (valid) begin
            v_cnt    = v_cnt + 1;
            v_duty   = duty;
            v_period = period;
            v_hi     = stuck_hi;
            v_lo     = stuck_lo;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Generator: high while its 2048-cycle counter <= d, optional 2-cycle low glitch.
    task automatic gen(input int d, input int cycles, input bit glitch);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            pwm_in = (gen_cnt <= d) && !(glitch && (gen_cnt == 500 || gen_cnt == 501));
            gen_cnt = (gen_cnt + 1) % 2048;
        end
        #1;
    endtask

    task automatic check_meas(input string tag, input int cnt, input int exp_cnt,
                              input int exp_duty, input int exp_period,
                              input bit exp_hi, input bit exp_lo);
        check({tag, "_count"}, cnt, exp_cnt);
        check({tag, "_duty"}, 32'(v_duty), exp_duty);
        check({tag, "_period"}, 32'(v_period), exp_period);
        check({tag, "_stuck_hi"}, 32'(v_hi), 32'(exp_hi));
        check({tag, "_stuck_lo"}, 32'(v_lo), 32'(exp_lo));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_duty"}, 32'(duty), 0);
        check({tag, "_period"}, 32'(period), 0);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_stuck_hi"}, 32'(stuck_hi), 0);
        check({tag, "_stuck_lo"}, 32'(stuck_lo), 0);
    endtask

    initial begin
        int base;
        int t;

        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");

        // Input held low from reset: one stuck_lo pulse about 4094 cycles in.
        @(negedge clk);
        rst_n = 1'b1;
        base = v_cnt;
        t = 0;
        while (!valid && t < 5000) begin
            @(negedge clk);
            t++;
        end
        #1;
        check("stuck_lo_latency_ok", 32'(t >= 4093 && t <= 4097), 1);
        check_meas("stuck_lo", v_cnt - base, 1, 0, 0, 1'b0, 1'b1);
        base = v_cnt;
        repeat (200) @(negedge clk);
        #1;
        check("stuck_lo_no_repeat", v_cnt - base, 0);

        base = v_cnt;
        gen(32'h200, 3 * 2048, 1'b0);
        check_meas("duty200", v_cnt - base, 2, 32'h200, 32'h800, 1'b0, 1'b0);

`ifndef PWM_CAP_GLITCH_FILTER_EN
        base = v_cnt;
        gen(0, 2 * 2048, 1'b0);
        check_meas("duty000", v_cnt - base, 2, 0, 32'h800, 1'b0, 1'b0);

        base = v_cnt;
        gen(32'h7FE, 2 * 2048, 1'b0);
        check_meas("duty7fe", v_cnt - base, 2, 32'h7FE, 32'h800, 1'b0, 1'b0);
`endif

        // Constant high: last full period, then a single stuck_hi report.
        base = v_cnt;
        gen(32'h7FF, 3 * 2048, 1'b0);
        check_meas("duty7ff", v_cnt - base, 2, 32'h7FF, 0, 1'b1, 1'b0);
        base = v_cnt;
        gen(32'h7FF, 2 * 2048, 1'b0);
        check("duty7ff_no_repeat", v_cnt - base, 0);

        base = v_cnt;
        gen(32'h100, 2048, 1'b0);
        check("duty100_discard_count", v_cnt - base, 0);
        check("duty100_stuck_hi_held", 32'(stuck_hi), 1);
        base = v_cnt;
        gen(32'h100, 2 * 2048, 1'b0);
        check_meas("duty100", v_cnt - base, 1, 32'h100, 32'h800, 1'b0, 1'b0);

        // Reset in the middle of a high phase.
        gen(32'h200, 100, 1'b0);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midhigh_reset");
        gen(32'h200, 3, 1'b0);
        rst_n = 1'b1;
        gen(32'h200, (2048 - 103) + 2 * 2048, 1'b0);
        check("post_reset_duty", 32'(v_duty), 32'h200);
        check("post_reset_period", 32'(v_period), 32'h800);

`ifdef PWM_CAP_GLITCH_FILTER_EN
        base = v_cnt;
        gen(999, 3 * 2048, 1'b1);
        check_meas("glitch", v_cnt - base, 2, 999, 32'h800, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
